note_lane_array: RTL and testbench
==================================

Name: note_lane_array

Overview:
- Parametrised successor to the 4-lane, 6-slot note handler for the rhythm game.
- Holds NUM_LANES independent lanes of SLOTS falling notes. Spawns notes on per-lane instruction pulses and advances them by a speed value on an internal frame tick.
- Resolves player hits inside a window around the hit line, and retires missed notes at the screen bottom.
- Feeds the VGA renderer (slot valid/position) and the scoring logic (hit/miss pulses).

Parameters:
- NUM_LANES, 4, number of lanes.
- SLOTS, 6, note slots per lane.
- POS_W, 9, vertical position width in pixels.
- SCREEN_H, 480, first off-screen row; a note reaching it is missed.
- HIT_Y, 440, hit-line row.
- HIT_WIN, 16, hit tolerance in pixels (inclusive, either side).
- TICK_DIV, 833333, clk cycles per movement tick (60 Hz at 50 MHz).

Ports:
- clk  in  1  system clock.
- RST_BTN_N  in  1  reset, asynchronous assert, active-low.
- speed  in  8  pixels advanced per tick; 0 freezes notes.
- instr  in  NUM_LANES  spawn request per lane, 1-cycle pulse.
- hit  in  NUM_LANES  debounced press per lane, 1-cycle pulse.
- slot_valid  out  NUM_LANES*SLOTS  slot occupied; index = lane*SLOTS+slot.
- slot_pos  out  NUM_LANES*SLOTS*POS_W  slot row, same indexing, POS_W bits per slot.
- hit_pulse  out  NUM_LANES  note hit this cycle.
- miss_pulse  out  NUM_LANES  note missed at bottom this cycle.
- overflow  out  NUM_LANES  spawn dropped because the lane was full.

Behaviour:
- Reset (RST_BTN_N low, async): all outputs 0, all slots invalid, positions 0, prescaler 0.
- Prescaler: counts 0..TICK_DIV-1 and wraps. The tick is high for one cycle when the count equals TICK_DIV-1. The prescaler runs regardless of speed.
- All evaluation uses pre-cycle (registered) state. Every output is registered and updates on the edge that consumes the event, so latency is 1 cycle.
- Spawn on instr[l]:
  - Allocate the lowest-index invalid slot of lane l: valid=1, pos=0.
  - If no slot is free, drop the request and pulse overflow[l] for 1 cycle.
  - A slot freed in the same cycle (hit or miss) cannot be reused until the next cycle.
- Movement on tick, for each valid slot not spawned or hit this cycle:
  - Compute sum = pos + speed in POS_W+1 bits, zero-extending speed.
  - If sum >= SCREEN_H: clear valid, set pos to 0, assert miss_pulse[l].
  - Otherwise pos = sum[POS_W-1:0].
  - The wrap-around guard is the extra bit; a note must never wrap to the top.
- Hit on hit[l]:
  - A slot is a candidate if valid and HIT_Y-HIT_WIN <= pos <= HIT_Y+HIT_WIN, with signed-safe comparison (the lower bound clamps at 0).
  - Select the candidate with the largest pos; ties go to the lowest slot index.
  - Clear the selected slot and assert hit_pulse[l]. It is neither advanced nor counted as a miss.
  - With no candidate, nothing happens: no pulse, no state change.
- Same-cycle combinations:
  - Spawn + tick: the new note stays at 0.
  - Hit + tick: the hit is judged on the pre-tick pos; other slots still advance.
  - Hit and miss in one lane, different slots: both pulses assert.
  - Several misses in one lane in one cycle: a single miss_pulse.
  - Spawn into a full lane on the same cycle a slot frees: overflow.
- Lanes are fully independent; the concurrent spawn/hit/miss handling above applies per lane.
- Reset asserted mid-operation clears everything asynchronously. There is no pending state after release.

Decomposition:
- Shared include/package note_defs: default NUM_LANES, SLOTS, POS_W, SCREEN_H, HIT_Y, HIT_WIN, TICK_DIV; index macro lane*SLOTS+slot.
- Sub-module note_lane: one lane holding SLOTS slots, with spawn allocator, hit selector and mover. It takes tick as an input.
- The top contains the prescaler and a generate loop of NUM_LANES note_lane instances.

Test Plan:
- Reset/spawn: reset, then instr=0001 for 1 cycle → next cycle slot_valid[0]=1, slot_pos[0]=0, other slots 0. instr=0010 → slot_valid[6]=1.
- Movement: speed=10, TICK_DIV=4, one note in lane 0 → pos 10, 20, 30 on successive ticks. speed=0 → pos unchanged across 3 ticks.
- Miss: note at pos 475, speed=10, tick → valid cleared, miss_pulse[0] high exactly 1 cycle. Note at 469, speed=10 → pos 479, no miss.
- Hit window, HIT_Y=440, HIT_WIN=16:
  - Notes at 430 and 450 in lane 2, hit[2] → slot at 450 cleared, hit_pulse[2]=1, 430 remains.
  - Note at 423 only → no pulse, no change.
- Full lane: 6 spawns in lane 3 fill slots 18-23. 7th spawn → overflow[3] pulse, valid unchanged. Spawn in the cycle a lane-3 note misses → still overflow; a spawn the next cycle succeeds into the freed slot.
- Async reset mid-tick: notes in all lanes; drop RST_BTN_N between clock edges → all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/note_lane_array_pkg.sv
// Shared defaults for the note lane array and a helper that maps a
// (lane, slot) pair onto the flat slot_valid / slot_pos vector index.
// No ports: imported by note_lane and note_lane_array.
package note_lane_array_pkg;

    localparam int unsigned DEF_NUM_LANES = 4;
    localparam int unsigned DEF_SLOTS     = 6;
    localparam int unsigned DEF_POS_W     = 9;
    localparam int unsigned DEF_SCREEN_H  = 480;
    localparam int unsigned DEF_HIT_Y     = 440;
    localparam int unsigned DEF_HIT_WIN   = 16;
    localparam int unsigned DEF_TICK_DIV  = 833333;

    // Flat index of a slot: lane*SLOTS + slot.
    function automatic int unsigned slot_idx(input int unsigned lane,
                                             input int unsigned slot,
                                             input int unsigned slots);
        return lane * slots + slot;
    endfunction

endpackage

// File: rtl/note_lane_array_lane.sv
// note_lane: one lane of SLOTS falling notes.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   tick            one-cycle movement strobe from the prescaler
//   speed           pixels advanced per tick
//   spawn, hit      one-cycle spawn request / player press
//   valid, pos      registered slot occupancy and rows (POS_W bits per slot)
//   hit_pulse       a note was hit on the last edge
//   miss_pulse      one or more notes fell off the bottom on the last edge
//   overflow        a spawn was dropped because the lane was full
module note_lane
    import note_lane_array_pkg::*;
#(
    parameter int unsigned SLOTS    = DEF_SLOTS,
    parameter int unsigned POS_W    = DEF_POS_W,
    parameter int unsigned SCREEN_H = DEF_SCREEN_H,
    parameter int unsigned HIT_Y    = DEF_HIT_Y,
    parameter int unsigned HIT_WIN  = DEF_HIT_WIN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick,
    input  logic [7:0]               speed,
    input  logic                     spawn,
    input  logic                     hit,
    output logic [SLOTS-1:0]         valid,
    output logic [SLOTS*POS_W-1:0]   pos,
    output logic                     hit_pulse,
    output logic                     miss_pulse,
    output logic                     overflow
);

    // Lower window bound clamps at 0 so an unsigned subtraction never wraps.
    localparam logic [31:0] WIN_LO = (HIT_Y > HIT_WIN) ? 32'(HIT_Y - HIT_WIN) : 32'd0;
    localparam logic [31:0] WIN_HI = 32'(HIT_Y + HIT_WIN);

    logic [SLOTS-1:0] valid_q, valid_d;
    logic [POS_W-1:0] pos_q [SLOTS];
    logic [POS_W-1:0] pos_d [SLOTS];
    logic             hit_pulse_q, hit_pulse_d;
    logic             miss_pulse_q, miss_pulse_d;
    logic             overflow_q, overflow_d;

    logic             cand_found;
    int               cand_idx;
    logic [POS_W-1:0] cand_pos;
    logic             free_found;
    int               free_idx;
    logic [POS_W:0]   sum;

    always_comb begin
        valid_d      = valid_q;
        pos_d        = pos_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        overflow_d   = 1'b0;
        cand_found   = 1'b0;
        cand_idx     = 0;
        cand_pos     = '0;
        free_found   = 1'b0;
        free_idx     = 0;
        sum          = '0;

        // Deepest note inside the window wins; strict '>' keeps ties on the
        // lowest slot index.
        for (int i = 0; i < SLOTS; i++) begin
            if (valid_q[i] && (32'(pos_q[i]) >= WIN_LO) && (32'(pos_q[i]) <= WIN_HI) &&
                (!cand_found || pos_q[i] > cand_pos)) begin
                cand_found = 1'b1;
                cand_idx   = i;
                cand_pos   = pos_q[i];
            end
        end

        // Allocation looks at registered occupancy only, so a slot freed on
        // this edge is not reusable until the next one.
        for (int i = 0; i < SLOTS; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = i;
            end
        end

        for (int i = 0; i < SLOTS; i++) begin
            if (hit && cand_found && cand_idx == i) begin
                valid_d[i]  = 1'b0;
                pos_d[i]    = '0;
                hit_pulse_d = 1'b1;
            end else if (valid_q[i] && tick) begin
                // Extra top bit catches the carry so a note never wraps upward.
                sum = {1'b0, pos_q[i]} + (POS_W+1)'(speed);
                if (32'(sum) >= SCREEN_H) begin
                    valid_d[i]   = 1'b0;
                    pos_d[i]     = '0;
                    miss_pulse_d = 1'b1;
                end else begin
                    pos_d[i] = sum[POS_W-1:0];
                end
            end
        end

        // Spawned slot was invalid, so it never overlaps a moved or hit slot.
        if (spawn) begin
            if (free_found) begin
                for (int i = 0; i < SLOTS; i++) begin
                    if (free_idx == i) begin
                        valid_d[i] = 1'b1;
                        pos_d[i]   = '0;
                    end
                end
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < SLOTS; i++) pos_q[i] <= '0;
        end else begin
            valid_q      <= valid_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            overflow_q   <= overflow_d;
            for (int i = 0; i < SLOTS; i++) pos_q[i] <= pos_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < SLOTS; i++) pos[i*POS_W +: POS_W] = pos_q[i];
    end

    assign valid      = valid_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign overflow   = overflow_q;

endmodule

// File: rtl/note_lane_array.sv
// note_lane_array: NUM_LANES independent note lanes plus the frame-tick
// prescaler that paces note movement.
// Ports:
//   clk         system clock
//   RST_BTN_N   asynchronous active-low reset
//   speed       pixels advanced per tick (0 freezes notes)
//   instr       per-lane spawn pulses
//   hit         per-lane debounced press pulses
//   slot_valid  slot occupancy, index lane*SLOTS+slot
//   slot_pos    slot rows, POS_W bits per slot, same indexing
//   hit_pulse / miss_pulse / overflow  per-lane one-cycle event flags
module note_lane_array
    import note_lane_array_pkg::*;
#(
    parameter int unsigned NUM_LANES = DEF_NUM_LANES,
    parameter int unsigned SLOTS     = DEF_SLOTS,
    parameter int unsigned POS_W     = DEF_POS_W,
    parameter int unsigned SCREEN_H  = DEF_SCREEN_H,
    parameter int unsigned HIT_Y     = DEF_HIT_Y,
    parameter int unsigned HIT_WIN   = DEF_HIT_WIN,
    parameter int unsigned TICK_DIV  = DEF_TICK_DIV
) (
    input  logic                             clk,
    input  logic                             RST_BTN_N,
    input  logic [7:0]                       speed,
    input  logic [NUM_LANES-1:0]             instr,
    input  logic [NUM_LANES-1:0]             hit,
    output logic [NUM_LANES*SLOTS-1:0]       slot_valid,
    output logic [NUM_LANES*SLOTS*POS_W-1:0] slot_pos,
    output logic [NUM_LANES-1:0]             hit_pulse,
    output logic [NUM_LANES-1:0]             miss_pulse,
    output logic [NUM_LANES-1:0]             overflow
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    // Free-running prescaler; the tick is decoded from the registered count.
    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge RST_BTN_N) begin
        if (!RST_BTN_N) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        note_lane #(
            .SLOTS    (SLOTS),
            .POS_W    (POS_W),
            .SCREEN_H (SCREEN_H),
            .HIT_Y    (HIT_Y),
            .HIT_WIN  (HIT_WIN)
        ) u_lane (
            .clk        (clk),
            .rst_n      (RST_BTN_N),
            .tick       (tick),
            .speed      (speed),
            .spawn      (instr[l]),
            .hit        (hit[l]),
            .valid      (slot_valid[slot_idx(l, 0, SLOTS) +: SLOTS]),
            .pos        (slot_pos[slot_idx(l, 0, SLOTS)*POS_W +: SLOTS*POS_W]),
            .hit_pulse  (hit_pulse[l]),
            .miss_pulse (miss_pulse[l]),
            .overflow   (overflow[l])
        );
    end

endmodule

// File: tb/tb_note_lane_array.sv
module tb_note_lane_array;

    localparam int NL = 4;
    localparam int NS = 6;
    localparam int PW = 9;

    logic                clk;
    logic                RST_BTN_N;
    logic [7:0]          speed;
    logic [NL-1:0]       instr;
    logic [NL-1:0]       hit;
    logic [NL*NS-1:0]    slot_valid;
    logic [NL*NS*PW-1:0] slot_pos;
    logic [NL-1:0]       hit_pulse;
    logic [NL-1:0]       miss_pulse;
    logic [NL-1:0]       overflow;

    int tests = 0;
    int fails = 0;
    int edges = 0;

    note_lane_array #(
        .NUM_LANES (NL),
        .SLOTS     (NS),
        .POS_W     (PW),
        .SCREEN_H  (480),
        .HIT_Y     (440),
        .HIT_WIN   (16),
        .TICK_DIV  (4)
    ) dut (
        .clk        (clk),
        .RST_BTN_N  (RST_BTN_N),
        .speed      (speed),
        .instr      (instr),
        .hit        (hit),
        .slot_valid (slot_valid),
        .slot_pos   (slot_pos),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pos_of(input int idx);
        return 64'(slot_pos[idx*PW +: PW]);
    endfunction

    // Inputs change 1 time unit after an edge; edges counts edges since reset
    // release, and with TICK_DIV=4 every 4th edge consumes a tick.
    task automatic cyc();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic to_tick();
        while ((edges + 1) % 4 != 0) cyc();
        cyc();
    endtask

    task automatic advance(input logic [7:0] s);
        while ((edges + 1) % 4 != 0) cyc();
        speed = s;
        cyc();
        speed = 8'd0;
    endtask

    task automatic pulse_instr(input logic [NL-1:0] v);
        instr = v;
        cyc();
        instr = '0;
    endtask

    task automatic pulse_hit(input logic [NL-1:0] v);
        hit = v;
        cyc();
        hit = '0;
    endtask

    initial begin
        RST_BTN_N = 1'b0;
        speed     = 8'd0;
        instr     = '0;
        hit       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(slot_valid), 64'd0);
        check("rst_pos_zero", 64'(slot_pos == '0), 64'd1);
        check("rst_pulses", 64'({hit_pulse, miss_pulse, overflow}), 64'd0);
        RST_BTN_N = 1'b1;
        edges = 0;

        // Spawn
        pulse_instr(4'b0001);
        check("spawn_l0_valid", 64'(slot_valid), 64'h000001);
        check("spawn_l0_pos", pos_of(0), 64'd0);
        pulse_instr(4'b0010);
        check("spawn_l1_valid", 64'(slot_valid), 64'h000041);

        // Movement at speed 10
        speed = 8'd10;
        to_tick();
        check("move_10", pos_of(0), 64'd10);
        check("move_10_l1", pos_of(6), 64'd10);
        cyc();
        check("no_move_off_tick", pos_of(0), 64'd10);
        to_tick();
        check("move_20", pos_of(0), 64'd20);
        to_tick();
        check("move_30", pos_of(0), 64'd30);
        speed = 8'd0;
        repeat (3) to_tick();
        check("frozen_speed0", pos_of(0), 64'd30);

        // Miss at bottom (lanes 0 and 1 move together)
        advance(8'd200);
        advance(8'd200);
        advance(8'd45);
        check("pos_475", pos_of(0), 64'd475);
        advance(8'd10);
        check("miss_valid", 64'(slot_valid), 64'd0);
        check("miss_pulse", 64'(miss_pulse), 64'b0011);
        cyc();
        check("miss_pulse_1cyc", 64'(miss_pulse), 64'd0);

        pulse_instr(4'b0001);
        advance(8'd200);
        advance(8'd200);
        advance(8'd69);
        advance(8'd10);
        check("pos_479", pos_of(0), 64'd479);
        check("no_miss_479", 64'(miss_pulse), 64'd0);
        check("valid_479", 64'(slot_valid), 64'h000001);
        advance(8'd1);
        check("miss_at_480", 64'(miss_pulse), 64'b0001);
        check("miss_480_valid", 64'(slot_valid), 64'd0);

        // Hit window in lane 2
        pulse_instr(4'b0100);
        advance(8'd20);
        pulse_instr(4'b0100);
        advance(8'd200);
        advance(8'd200);
        advance(8'd30);
        check("hit_setup_450", pos_of(12), 64'd450);
        check("hit_setup_430", pos_of(13), 64'd430);
        pulse_hit(4'b0100);
        check("hit_pulse_deepest", 64'(hit_pulse), 64'b0100);
        check("hit_clears_450", 64'(slot_valid), 64'h002000);
        check("hit_keeps_430", pos_of(13), 64'd430);
        cyc();
        check("hit_pulse_1cyc", 64'(hit_pulse), 64'd0);
        pulse_hit(4'b0100);
        check("hit_430", 64'(hit_pulse), 64'b0100);
        check("hit_430_valid", 64'(slot_valid), 64'd0);

        pulse_instr(4'b0100);
        advance(8'd200);
        advance(8'd200);
        advance(8'd23);
        pulse_hit(4'b0100);
        check("no_hit_423", 64'(hit_pulse), 64'd0);
        check("no_hit_423_valid", 64'(slot_valid), 64'h001000);
        check("no_hit_423_pos", pos_of(12), 64'd423);
        advance(8'd1);
        pulse_hit(4'b0100);
        check("hit_lo_edge_424", 64'(hit_pulse), 64'b0100);
        check("hit_424_valid", 64'(slot_valid), 64'd0);

        // Full lane 3
        repeat (6) pulse_instr(4'b1000);
        check("full_valid", 64'(slot_valid), 64'hFC0000);
        check("full_no_ovf", 64'(overflow), 64'd0);
        pulse_instr(4'b1000);
        check("ovf_pulse", 64'(overflow), 64'b1000);
        check("ovf_valid_same", 64'(slot_valid), 64'hFC0000);
        cyc();
        check("ovf_1cyc", 64'(overflow), 64'd0);

        advance(8'd200);
        advance(8'd200);
        advance(8'd75);
        check("full_pos_475", pos_of(23), 64'd475);
        while ((edges + 1) % 4 != 0) cyc();
        speed = 8'd10;
        instr = 4'b1000;
        cyc();
        speed = 8'd0;
        instr = '0;
        check("ovf_on_free", 64'(overflow), 64'b1000);
        check("multi_miss_single", 64'(miss_pulse), 64'b1000);
        check("multi_miss_valid", 64'(slot_valid), 64'd0);
        pulse_instr(4'b1000);
        check("reuse_no_ovf", 64'(overflow), 64'd0);
        check("reuse_slot18", 64'(slot_valid), 64'h040000);

        // Async reset between edges
        pulse_instr(4'b0111);
        check("all_lanes_valid", 64'(slot_valid), 64'h041041);
        advance(8'd50);
        check("all_lanes_pos0", pos_of(0), 64'd50);
        check("all_lanes_pos18", pos_of(18), 64'd50);
        @(posedge clk);
        #2;
        RST_BTN_N = 1'b0;
        #1;
        check("async_rst_valid", 64'(slot_valid), 64'd0);
        check("async_rst_pos_zero", 64'(slot_pos == '0), 64'd1);
        check("async_rst_pulses", 64'({hit_pulse, miss_pulse, overflow}), 64'd0);
        #3;
        RST_BTN_N = 1'b1;
        edges = 0;
        repeat (6) cyc();
        check("post_rst_idle", 64'(slot_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
